// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk by 4 into a pixel tick and produces counters, strobes and registered sync/colour pins.
// Optional colour-bar test pattern is included when VGA_TESTPAT_EN is defined (adds input testMode).
module vga_timing_gen #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 514
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgbIn,
`ifdef VGA_TESTPAT_EN
    input  logic        testMode,
`endif
    output logic        pixClk,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        lineStart,
    output logic        frameStart,
    output logic [15:0] frameCount,
    output logic        hSync,
    output logic        vSync,
    output logic [11:0] vgaRgb
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] V_SW   = 10'(V_SYNC);
    localparam logic [9:0] H_VS   = 10'(H_VIS_START);
    localparam logic [9:0] H_VE   = 10'(H_VIS_END);
    localparam logic [9:0] V_VS   = 10'(V_VIS_START);
    localparam logic [9:0] V_VE   = 10'(V_VIS_END);

    logic [1:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic [11:0] rgb_q, rgb_d;
    logic        pe;
    logic        visible;
    logic [11:0] pix_src;

    assign pe      = (div_cnt_q == 2'd3);
    assign visible = (h_cnt_q >= H_VS) && (h_cnt_q <= H_VE) &&
                     (v_cnt_q >= V_VS) && (v_cnt_q <= V_VE);

`ifdef VGA_TESTPAT_EN
    logic [9:0]  bar_col;
    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;

    // Column offset is only meaningful inside the visible window; outside it the pixel is blanked anyway.
    assign bar_col = h_cnt_q - H_VS;
    assign bar_idx = 3'(bar_col / 10'd80);

    always_comb begin
        bar_rgb = 12'h000;
        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    assign pix_src = testMode ? bar_rgb : rgbIn;
`else
    assign pix_src = rgbIn;
`endif

    always_comb begin
        div_cnt_d   = div_cnt_q + 2'd1;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        h_sync_d    = h_sync_q;
        v_sync_d    = v_sync_q;
        rgb_d       = rgb_q;
        if (pe) begin
            // Pins sample the counters before they advance, so they trail by one pixel period.
            h_sync_d = (h_cnt_q >= H_SW);
            v_sync_d = (v_cnt_q >= V_SW);
            rgb_d    = visible ? pix_src : 12'h000;
            if (h_cnt_q >= H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q >= V_LAST) begin
                    v_cnt_d     = 10'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= 2'd0;
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            frame_cnt_q <= 16'd0;
            h_sync_q    <= 1'b1;
            v_sync_q    <= 1'b1;
            rgb_q       <= 12'h000;
        end else begin
            div_cnt_q   <= div_cnt_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            rgb_q       <= rgb_d;
        end
    end

    assign pixClk     = div_cnt_q[1];
    assign hCount     = h_cnt_q;
    assign vCount     = v_cnt_q;
    assign bright     = visible;
    assign lineStart  = (h_cnt_q == 10'd0);
    assign frameStart = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign frameCount = frame_cnt_q;
    assign hSync      = h_sync_q;
    assign vSync      = v_sync_q;
    assign vgaRgb     = rgb_q;

endmodule
